mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/arb_wait_counter.sv | 35 +++
 rtl/mem_port_arbiter.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg -- shared types and default sizes for the memory port arbiter.
//   arb_state_e     : arbiter FSM state (IDLE, IF_BUSY, D_BUSY)
//   DEF_DATA_W      : default data bus width
//   DEF_ADDR_W      : default byte address width
//   DEF_MAX_WAIT    : default fetch-starvation limit (used with ARB_STARVE_GUARD_EN)
package mem_arb_pkg;

   localparam int DEF_DATA_W   = 32;
   localparam int DEF_ADDR_W   = 32;
   localparam int DEF_MAX_WAIT = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      IF_BUSY = 2'd1,
      D_BUSY  = 2'd2
   } arb_state_e;

endpackage

// File: rtl/arb_wait_counter.sv
// arb_wait_counter -- saturating up-counter with synchronous clear.
//   clk, reset : clock, synchronous active-high reset
//   inc        : count one more event (ignored once saturated)
//   clr        : clear to 0 (wins over inc)
//   at_max     : count has reached MAX
module arb_wait_counter #(
   parameter int MAX = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic inc,
   input  logic clr,
   output logic at_max
);

   localparam int CNT_W = $clog2(MAX + 1);

   logic [CNT_W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clr)
         count_d = '0;
      else if (inc && (count_q != CNT_W'(MAX)))
         count_d = count_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) count_q <= '0;
      else       count_q <= count_d;
   end

   assign at_max = (count_q == CNT_W'(MAX));

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter -- shares one memory port between an instruction-fetch
// port (read only) and a data port (read/write). One access outstanding.
//   clk, reset                      : clock, synchronous active-high reset
//   if_req/if_addr -> if_gnt        : fetch request / combinational accept
//   if_valid/if_rdata               : fetch response pulse and data
//   d_req/d_we/d_addr/d_wdata       : data request
//   d_gnt, d_valid/d_rdata          : data accept, response pulse and data
//   m_addr/m_wdata/m_read/m_write   : registered memory request
//   m_rdata/m_ready                 : memory response
// Optional macro ARB_STARVE_GUARD_EN: after MAX_WAIT consecutive data grants
// that left a fetch waiting, the next grant goes to fetch. Without it, data
// always has priority.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int MAX_WAIT = DEF_MAX_WAIT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_valid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic              d_valid,
   output logic [DATA_W-1:0] d_rdata,
   output logic [ADDR_W-1:0] m_addr,
   output logic [DATA_W-1:0] m_wdata,
   output logic              m_read,
   output logic              m_write,
   input  logic [DATA_W-1:0] m_rdata,
   input  logic              m_ready
);

   arb_state_e        state_q, state_d;
   logic [ADDR_W-1:0] m_addr_q, m_addr_d;
   logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
   logic              m_read_q, m_read_d;
   logic              m_write_q, m_write_d;
   logic              if_valid_q, if_valid_d;
   logic              d_valid_q, d_valid_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

   logic idle;
   logic force_if;

   // No grant may escape while reset is held.
   assign idle   = (state_q == IDLE) && !reset;
   assign d_gnt  = idle && d_req && !(force_if && if_req);
   assign if_gnt = idle && if_req && !d_gnt;

`ifdef ARB_STARVE_GUARD_EN
   arb_wait_counter #(.MAX(MAX_WAIT)) u_wait_counter (
      .clk    (clk),
      .reset  (reset),
      .inc    (idle && if_req && d_gnt),
      .clr    (if_gnt),
      .at_max (force_if)
   );
`else
   assign force_if = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      m_addr_d   = m_addr_q;
      m_wdata_d  = m_wdata_q;
      m_read_d   = m_read_q;
      m_write_d  = m_write_q;
      if_valid_d = 1'b0;
      d_valid_d  = 1'b0;
      if_rdata_d = if_rdata_q;
      d_rdata_d  = d_rdata_q;
      case (state_q)
         IDLE: begin
            // m_ready is deliberately not looked at here.
            m_read_d  = 1'b0;
            m_write_d = 1'b0;
            if (d_gnt) begin
               state_d   = D_BUSY;
               m_addr_d  = {d_addr[ADDR_W-1:2], 2'b00};
               m_wdata_d = d_wdata;
               m_read_d  = !d_we;
               m_write_d = d_we;
            end else if (if_gnt) begin
               state_d  = IF_BUSY;
               m_addr_d = {if_addr[ADDR_W-1:2], 2'b00};
               m_read_d = 1'b1;
            end
         end
         IF_BUSY: begin
            if (m_ready) begin
               state_d    = IDLE;
               m_read_d   = 1'b0;
               if_valid_d = 1'b1;
               if_rdata_d = m_rdata;
            end
         end
         D_BUSY: begin
            if (m_ready) begin
               state_d   = IDLE;
               m_read_d  = 1'b0;
               m_write_d = 1'b0;
               d_valid_d = 1'b1;
               // A write completes with zero read data.
               d_rdata_d = m_write_q ? '0 : m_rdata;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         m_addr_q   <= '0;
         m_wdata_q  <= '0;
         m_read_q   <= 1'b0;
         m_write_q  <= 1'b0;
         if_valid_q <= 1'b0;
         d_valid_q  <= 1'b0;
         if_rdata_q <= '0;
         d_rdata_q  <= '0;
      end else begin
         state_q    <= state_d;
         m_addr_q   <= m_addr_d;
         m_wdata_q  <= m_wdata_d;
         m_read_q   <= m_read_d;
         m_write_q  <= m_write_d;
         if_valid_q <= if_valid_d;
         d_valid_q  <= d_valid_d;
         if_rdata_q <= if_rdata_d;
         d_rdata_q  <= d_rdata_d;
      end
   end

   assign m_addr   = m_addr_q;
   assign m_wdata  = m_wdata_q;
   assign m_read   = m_read_q;
   assign m_write  = m_write_q;
   assign if_valid = if_valid_q;
   assign d_valid  = d_valid_q;
   assign if_rdata = if_rdata_q;
   assign d_rdata  = d_rdata_q;

endmodule
